uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 121 ++++++++++++
 tb/tb_uart_tx_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit sequencer: start, 8 data LSB first, even parity, stop.
// Each bit spans OVERSAMPLE sample_ENABLE ticks; baud code is frozen while a frame is in flight.
module uart_tx_sequencer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_ENABLE,
    input  logic [2:0] baud_select_in,
    output logic [2:0] baud_select_out,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    state_t     state, state_n;
    logic [3:0] tick_cnt, tick_n;
    logic [2:0] bit_idx, bit_n;
    logic [2:0] bit_idx_inc;
    logic [7:0] data_reg, data_n;
    logic       txd_n, busy_n, done_n;
    logic [2:0] baud_n;

    assign bit_idx_inc = bit_idx + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            tick_cnt        <= 4'd0;
            bit_idx         <= 3'd0;
            data_reg        <= 8'd0;
            TxD             <= 1'b1;
            Tx_BUSY         <= 1'b0;
            Tx_DONE         <= 1'b0;
            baud_select_out <= 3'b000;
        end else begin
            state           <= state_n;
            tick_cnt        <= tick_n;
            bit_idx         <= bit_n;
            data_reg        <= data_n;
            TxD             <= txd_n;
            Tx_BUSY         <= busy_n;
            Tx_DONE         <= done_n;
            baud_select_out <= baud_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_idx;
        data_n  = data_reg;
        txd_n   = TxD;
        busy_n  = Tx_BUSY;
        done_n  = 1'b0;
        baud_n  = baud_select_out;

        if (state == IDLE) begin
            // Ticks are not counted in IDLE, so one coincident with the accepting write is dropped.
            baud_n = baud_select_in;
            if (Tx_WR && Tx_EN) begin
                state_n = START;
                data_n  = Tx_DATA;
                txd_n   = 1'b0;
                busy_n  = 1'b1;
                tick_n  = 4'd0;
                bit_n   = 3'd0;
            end
        end else if (sample_ENABLE) begin
            if (tick_cnt == TICK_LAST) begin
                tick_n = 4'd0;
                case (state)
                    START: begin
                        state_n = DATA;
                        txd_n   = data_reg[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state_n = PARITY;
                            txd_n   = ^data_reg;
                        end else begin
                            bit_n = bit_idx_inc;
                            txd_n = data_reg[bit_idx_inc];
                        end
                    end
                    PARITY: begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end
                    STOP: begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                    default: begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                        busy_n  = 1'b0;
                    end
                endcase
            end else begin
                tick_n = tick_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - directed self-checking bench for uart_tx_sequencer.
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_ENABLE;
    logic [2:0] baud_select_in;
    logic [2:0] baud_select_out;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_tx_sequencer #(.OVERSAMPLE(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_ENABLE  (sample_ENABLE),
        .baud_select_in (baud_select_in),
        .baud_select_out(baud_select_out),
        .Tx_EN          (Tx_EN),
        .Tx_WR          (Tx_WR),
        .Tx_DATA        (Tx_DATA),
        .TxD            (TxD),
        .Tx_BUSY        (Tx_BUSY),
        .Tx_DONE        (Tx_DONE)
    );

    always #5 clk = ~clk;

    // Frame vectors {stop, parity, data[7:0], start}; bit 0 goes out first.
    localparam logic [10:0] BITS_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] BITS_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] BITS_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] BITS_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] BITS_55 = 11'b1_0_01010101_0;
    localparam logic [10:0] BITS_5B = 11'b1_1_01011011_0;
    localparam logic [10:0] BITS_C3 = 11'b1_0_11000011_0;

    task automatic send(input logic [7:0] d, input string nm);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        @(posedge clk); #1;
        Tx_WR   = 1'b0;
        tests_run++;
        if (Tx_BUSY !== 1'b1 || TxD !== 1'b0 || Tx_DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_accept: busy=%b txd=%b done=%b expected busy=1 txd=0 done=0",
                     nm, Tx_BUSY, TxD, Tx_DONE);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_ENABLE = 1'b1;
            @(posedge clk); #1;
            sample_ENABLE = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input logic [10:0] bits, input logic [2:0] baud, input string nm);
        int dc = 0;
        for (int b = 0; b < 11; b++) begin
            for (int t = 0; t < 16; t++) begin
                tests_run++;
                if (TxD !== bits[b] || Tx_BUSY !== 1'b1 || baud_select_out !== baud) begin
                    tests_failed++;
                    $display("FAIL %s_bit%0d_tick%0d: txd=%b busy=%b baud=%b expected txd=%b busy=1 baud=%b",
                             nm, b, t, TxD, Tx_BUSY, baud_select_out, bits[b], baud);
                end
                sample_ENABLE = 1'b1;
                @(posedge clk); #1;
                sample_ENABLE = 1'b0;
                if (Tx_DONE === 1'b1) dc++;
                if (!(b == 10 && t == 15)) begin
                    @(posedge clk); #1;
                    if (Tx_DONE === 1'b1) dc++;
                end
            end
        end
        tests_run++;
        if (Tx_DONE !== 1'b1 || Tx_BUSY !== 1'b0 || TxD !== 1'b1 || dc != 1 || baud_select_out !== baud) begin
            tests_failed++;
            $display("FAIL %s_end: done=%b busy=%b txd=%b done_count=%0d baud=%b expected done=1 busy=0 txd=1 done_count=1 baud=%b",
                     nm, Tx_DONE, Tx_BUSY, TxD, dc, baud_select_out, baud);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        sample_ENABLE  = 1'b0;
        Tx_EN          = 1'b1;
        Tx_WR          = 1'b0;
        Tx_DATA        = 8'h00;
        baud_select_in = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0 || baud_select_out !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_state: txd=%b busy=%b done=%b baud=%b expected 1 0 0 000",
                     TxD, Tx_BUSY, Tx_DONE, baud_select_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_frame_a5();
        send(8'hA5, "a5");
        run_frame(BITS_A5, 3'b010, "a5");
        @(posedge clk); #1;
        tests_run++;
        if (Tx_DONE !== 1'b0 || TxD !== 1'b1) begin
            tests_failed++;
            $display("FAIL a5_done_width: done=%b txd=%b expected done=0 txd=1", Tx_DONE, TxD);
        end
    endtask

    task automatic test_parity_back_to_back();
        send(8'h07, "p07");
        run_frame(BITS_07, 3'b010, "p07");
        send(8'h00, "p00");
        run_frame(BITS_00, 3'b010, "p00");
        @(posedge clk); #1;
        tests_run++;
        if (Tx_DONE !== 1'b0 || Tx_BUSY !== 1'b0 || TxD !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle: done=%b busy=%b txd=%b expected 0 0 1", Tx_DONE, Tx_BUSY, TxD);
        end
    endtask

    task automatic test_busy_ignore();
        Tx_DATA = 8'h3C;
        Tx_WR   = 1'b1;
        @(posedge clk); #1;
        Tx_DATA = 8'hFF;
        @(posedge clk); #1;
        Tx_WR   = 1'b0;
        @(posedge clk); #1;
        Tx_WR   = 1'b1;
        @(posedge clk); #1;
        Tx_WR   = 1'b0;
        run_frame(BITS_3C, 3'b010, "busy");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0 || TxD !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy_no_queue_%0d: busy=%b done=%b txd=%b expected 0 0 1",
                         i, Tx_BUSY, Tx_DONE, TxD);
            end
        end
    endtask

    task automatic test_baud_defer();
        baud_select_in = 3'b001;
        @(posedge clk); #1;
        tests_run++;
        if (baud_select_out !== 3'b001) begin
            tests_failed++;
            $display("FAIL baud_idle_track: baud=%b expected 001", baud_select_out);
        end
        send(8'h55, "baud");
        baud_select_in = 3'b110;
        run_frame(BITS_55, 3'b001, "baud");
        @(posedge clk); #1;
        tests_run++;
        if (baud_select_out !== 3'b110 || Tx_DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL baud_release: baud=%b done=%b expected 110 0", baud_select_out, Tx_DONE);
        end
        baud_select_in = 3'b010;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int dc = 0;
        send(8'h86, "rst");
        do_ticks(5 * 16 + 8);
        tests_run++;
        if (TxD !== 1'b0 || Tx_BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_in_bit4: txd=%b busy=%b expected 0 1", TxD, Tx_BUSY);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0 || baud_select_out !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_async: txd=%b busy=%b done=%b baud=%b expected 1 0 0 000",
                     TxD, Tx_BUSY, Tx_DONE, baud_select_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (Tx_DONE === 1'b1) dc++;
        end
        reset = 1'b0;
        tests_run++;
        if (dc != 0) begin
            tests_failed++;
            $display("FAIL rst_no_done: done_count=%0d expected 0", dc);
        end
        send(8'h5B, "rst_new");
        run_frame(BITS_5B, 3'b010, "rst_new");
        @(posedge clk); #1;
    endtask

    task automatic test_tx_en_drop();
        send(8'hC3, "en");
        Tx_EN = 1'b0;
        run_frame(BITS_C3, 3'b010, "en");
        Tx_DATA = 8'hFF;
        Tx_WR   = 1'b1;
        @(posedge clk); #1;
        Tx_WR   = 1'b0;
        tests_run++;
        if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_off_write: busy=%b txd=%b expected 0 1", Tx_BUSY, TxD);
        end
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) begin
                tests_failed++;
                $display("FAIL en_off_idle_%0d: txd=%b busy=%b done=%b expected 1 0 0",
                         i, TxD, Tx_BUSY, Tx_DONE);
            end
            do_ticks(1);
        end
        Tx_EN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity_back_to_back();
        test_busy_ignore();
        test_baud_defer();
        test_reset_mid_frame();
        test_tx_en_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
